dly_tap_cal_ctrl: RTL and testbench

//  Calibration sequencer for the tapped DELAY4 delay line in the clock/strobe path.

---
 rtl/dly_cal_pkg.sv | 21 ++
 rtl/dly_cal_win_cnt.sv | 48 ++++
 rtl/dly_tap_cal_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_dly_tap_cal_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dly_cal_pkg.sv
// Shared types and default constants for the delay-line tap calibration sequencer.
// The DLY_CAL_TRACK_EN build option adds the TRACK state used after a successful lock.
package dly_cal_pkg;

    localparam int DEF_NTAPS      = 16;
    localparam int DEF_TAP_W      = 4;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_NSAMP      = 16;
    localparam int DEF_CNT_W      = 5;
    localparam int DEF_LEN_W      = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        EVAL   = 3'd3,
        DONE   = 3'd4,
        TRACK  = 3'd5
    } cal_state_e;

endpackage

// File: rtl/dly_cal_win_cnt.sv
// Settle/sample window down-counter with a ones accumulator for the phase samples.
// load presets the window length; expired flags the last cycle of a running window.
module dly_cal_win_cnt import dly_cal_pkg::*; #(
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             clr,
    input  logic             run,
    input  logic             acc,
    input  logic             smp,
    output logic             expired,
    output logic [CNT_W-1:0] ones
);

    logic [LEN_W-1:0] cnt_r;
    logic [CNT_W-1:0] ones_r;

    // window length counter and ones accumulator; clr wins over acc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {LEN_W{1'b0}};
            ones_r <= {CNT_W{1'b0}};
        end else begin
            if (load) begin
                cnt_r <= len;
            end else if (run && (cnt_r != {LEN_W{1'b0}})) begin
                cnt_r <= cnt_r - LEN_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (clr) begin
                ones_r <= {CNT_W{1'b0}};
            end else if (acc) begin
                ones_r <= ones_r + {{(CNT_W-1){1'b0}}, smp};
            end else begin
                ones_r <= ones_r;
            end
        end
    end

    assign expired = run && (cnt_r == LEN_W'(1));
    assign ones    = ones_r;

endmodule

// File: rtl/dly_tap_cal_ctrl.sv
// Tap sweep sequencer: locks on the first tap whose majority-vote phase rises 0->1.
// Define DLY_CAL_TRACK_EN to keep nudging the locked tap from continuous sample windows.
module dly_tap_cal_ctrl import dly_cal_pkg::*; #(
    parameter int NTAPS      = DEF_NTAPS,
    parameter int TAP_W      = DEF_TAP_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int NSAMP      = DEF_NSAMP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ph_smp,
    output logic [TAP_W-1:0] tap_sel,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             fail,
    output logic [TAP_W-1:0] lock_tap
);

    localparam int WIN_MAX = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
    localparam int LEN_W   = $clog2(WIN_MAX + 1);

    localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0] MAJ_THR    = CNT_W'(NSAMP / 2);
    localparam logic [LEN_W-1:0] LEN_SETTLE = LEN_W'(SETTLE_CYC);
    localparam logic [LEN_W-1:0] LEN_SAMPLE = LEN_W'(NSAMP);

    cal_state_e       state_r, state_s;
    logic [TAP_W-1:0] tap_r, tap_s;
    logic [TAP_W-1:0] lock_tap_r, lock_tap_s;
    logic             prev_maj_r, prev_maj_s;
    logic             locked_r, locked_s;
    logic             fail_r, fail_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic             win_load_s, win_clr_s, win_run_s, win_acc_s, win_exp_s;
    logic [LEN_W-1:0] win_len_s;
    logic [CNT_W-1:0] ones_s;
    logic             maj_s;

`ifdef DLY_CAL_TRACK_EN
    localparam logic [CNT_W-1:0] TRK_LO = CNT_W'(NSAMP / 4);
    localparam logic [CNT_W-1:0] TRK_HI = CNT_W'((3 * NSAMP) / 4);
    localparam logic [TAP_W-1:0] TAP_ONE = TAP_W'(1);

    logic             trk_settle_r, trk_settle_s;
    logic [CNT_W-1:0] ones_tot_s;

    // tracking decides on the window's last cycle, so fold in the sample not yet accumulated
    assign ones_tot_s = ones_s + {{(CNT_W-1){1'b0}}, ph_smp};
`endif

    dly_cal_win_cnt #(
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) u_win_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (win_load_s),
        .len     (win_len_s),
        .clr     (win_clr_s),
        .run     (win_run_s),
        .acc     (win_acc_s),
        .smp     (ph_smp),
        .expired (win_exp_s),
        .ones    (ones_s)
    );

    // a tie is not a majority
    assign maj_s = (ones_s > MAJ_THR);

    // next-state and next-output decode
    always_comb begin
        state_s    = state_r;
        tap_s      = tap_r;
        lock_tap_s = lock_tap_r;
        prev_maj_s = prev_maj_r;
        locked_s   = locked_r;
        fail_s     = fail_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        win_load_s = 1'b0;
        win_len_s  = LEN_SETTLE;
        win_clr_s  = 1'b0;
        win_run_s  = 1'b0;
        win_acc_s  = 1'b0;
`ifdef DLY_CAL_TRACK_EN
        trk_settle_s = trk_settle_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    tap_s      = {TAP_W{1'b0}};
                    prev_maj_s = 1'b0;
                    locked_s   = 1'b0;
                    fail_s     = 1'b0;
                    busy_s     = 1'b1;
                    win_load_s = 1'b1;
                    win_len_s  = LEN_SETTLE;
                    state_s    = SETTLE;
`ifdef DLY_CAL_TRACK_EN
                end else if (locked_r) begin
                    win_load_s   = 1'b1;
                    win_len_s    = LEN_SAMPLE;
                    win_clr_s    = 1'b1;
                    trk_settle_s = 1'b0;
                    state_s      = TRACK;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                win_run_s = 1'b1;
                if (win_exp_s) begin
                    win_load_s = 1'b1;
                    win_len_s  = LEN_SAMPLE;
                    win_clr_s  = 1'b1;
                    state_s    = SAMPLE;
                end else begin
                    state_s = SETTLE;
                end
            end
            SAMPLE: begin
                win_run_s = 1'b1;
                win_acc_s = 1'b1;
                if (win_exp_s) begin
                    state_s = EVAL;
                end else begin
                    state_s = SAMPLE;
                end
            end
            EVAL: begin
                if (!prev_maj_r && maj_s && (tap_r != {TAP_W{1'b0}})) begin
                    lock_tap_s = tap_r;
                    locked_s   = 1'b1;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    state_s    = DONE;
                end else if (tap_r == TAP_LAST) begin
                    tap_s      = {TAP_W{1'b0}};
                    lock_tap_s = {TAP_W{1'b0}};
                    fail_s     = 1'b1;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    state_s    = DONE;
                end else begin
                    prev_maj_s = maj_s;
                    tap_s      = tap_r + TAP_W'(1);
                    win_load_s = 1'b1;
                    win_len_s  = LEN_SETTLE;
                    state_s    = SETTLE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
`ifdef DLY_CAL_TRACK_EN
            TRACK: begin
                if (start) begin
                    tap_s        = {TAP_W{1'b0}};
                    prev_maj_s   = 1'b0;
                    locked_s     = 1'b0;
                    fail_s       = 1'b0;
                    busy_s       = 1'b1;
                    win_load_s   = 1'b1;
                    win_len_s    = LEN_SETTLE;
                    trk_settle_s = 1'b0;
                    state_s      = SETTLE;
                end else if (trk_settle_r) begin
                    win_run_s = 1'b1;
                    if (win_exp_s) begin
                        win_load_s   = 1'b1;
                        win_len_s    = LEN_SAMPLE;
                        win_clr_s    = 1'b1;
                        trk_settle_s = 1'b0;
                    end else begin
                        trk_settle_s = 1'b1;
                    end
                end else begin
                    win_run_s = 1'b1;
                    win_acc_s = 1'b1;
                    if (win_exp_s && (ones_tot_s < TRK_LO) && (tap_r != TAP_LAST)) begin
                        tap_s        = tap_r + TAP_W'(1);
                        lock_tap_s   = tap_r + TAP_W'(1);
                        win_load_s   = 1'b1;
                        win_len_s    = LEN_SETTLE;
                        trk_settle_s = 1'b1;
                    end else if (win_exp_s && (ones_tot_s > TRK_HI) && (tap_r > TAP_ONE)) begin
                        tap_s        = tap_r - TAP_W'(1);
                        lock_tap_s   = tap_r - TAP_W'(1);
                        win_load_s   = 1'b1;
                        win_len_s    = LEN_SETTLE;
                        trk_settle_s = 1'b1;
                    end else if (win_exp_s) begin
                        win_load_s = 1'b1;
                        win_len_s  = LEN_SAMPLE;
                        win_clr_s  = 1'b1;
                    end else begin
                        trk_settle_s = 1'b0;
                    end
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            tap_r      <= {TAP_W{1'b0}};
            lock_tap_r <= {TAP_W{1'b0}};
            prev_maj_r <= 1'b0;
            locked_r   <= 1'b0;
            fail_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tap_r      <= tap_s;
            lock_tap_r <= lock_tap_s;
            prev_maj_r <= prev_maj_s;
            locked_r   <= locked_s;
            fail_r     <= fail_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

`ifdef DLY_CAL_TRACK_EN
    // tracking sub-phase: 1 while waiting out the settle time after a tap step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_settle_r <= 1'b0;
        end else begin
            trk_settle_r <= trk_settle_s;
        end
    end
`endif

    assign tap_sel  = tap_r;
    assign lock_tap = lock_tap_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign locked   = locked_r;
    assign fail     = fail_r;

endmodule

// File: tb/tb_dly_tap_cal_ctrl.sv
// Directed self-checking bench for dly_tap_cal_ctrl with a behavioural delay-line phase model.
// The tracking scenario is only exercised when DLY_CAL_TRACK_EN is defined.
module tb_dly_tap_cal_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ph_smp;
    logic [3:0] tap_sel;
    logic       busy;
    logic       done;
    logic       locked;
    logic       fail;
    logic [3:0] lock_tap;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int cyc    = 0;

    dly_tap_cal_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ph_smp   (ph_smp),
        .tap_sel  (tap_sel),
        .busy     (busy),
        .done     (done),
        .locked   (locked),
        .fail     (fail),
        .lock_tap (lock_tap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // delay-line model: 0 all low, 1 all high, 2 edge at tap 5, 3 noisy with edge at tap 7
    always @(negedge clk) begin
        cyc = cyc + 1;
        case (mode)
            0: ph_smp = 1'b0;
            1: ph_smp = 1'b1;
            2: ph_smp = (tap_sel >= 4'd5);
            3: ph_smp = (tap_sel >= 4'd7) ? (cyc[1:0] != 2'b00) : cyc[0];
            default: ph_smp = 1'b0;
        endcase
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // pulse start and return cycles until done (-1 on timeout); returns inside the done cycle
    task automatic run_sweep(output int lat);
        start = 1'b1;
        step(1);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 1000; n++) begin
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        step(3);
        checks++;
        if ({tap_sel, busy, done, locked, fail, lock_tap} !== 12'h000) begin
            errors++;
            $display("FAIL reset_vals: got %h expected 000", {tap_sel, busy, done, locked, fail, lock_tap});
        end
        rst_n = 1'b1;
        step(10);
        checks++;
        if ({tap_sel, busy, done, locked, fail, lock_tap} !== 12'h000) begin
            errors++;
            $display("FAIL idle_hold: got %h expected 000", {tap_sel, busy, done, locked, fail, lock_tap});
        end
    endtask

    task automatic test_edge_lock();
        int lat;
        mode = 2;
        run_sweep(lat);
        checks++;
        if (lat !== 151) begin errors++; $display("FAIL edge_latency: got %0d expected 151", lat); end
        checks++;
        if (locked !== 1'b1 || fail !== 1'b0) begin
            errors++; $display("FAIL edge_flags: locked=%b fail=%b expected 1 0", locked, fail);
        end
        checks++;
        if (lock_tap !== 4'd5) begin errors++; $display("FAIL edge_lock_tap: got %0d expected 5", lock_tap); end
        checks++;
        if (tap_sel !== 4'd5) begin errors++; $display("FAIL edge_tap_sel: got %0d expected 5", tap_sel); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL edge_busy: got %b expected 0", busy); end
        step(1);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done); end
`ifndef DLY_CAL_TRACK_EN
        step(20);
        checks++;
        if (tap_sel !== 4'd5 || locked !== 1'b1) begin
            errors++; $display("FAIL tap_static: tap_sel=%0d locked=%b expected 5 1", tap_sel, locked);
        end
`endif
    endtask

    task automatic test_fail();
        int lat;
        for (int m = 0; m < 2; m++) begin
            mode = m;
            run_sweep(lat);
            checks++;
            if (lat !== 401) begin errors++; $display("FAIL fail_latency_m%0d: got %0d expected 401", m, lat); end
            checks++;
            if (fail !== 1'b1 || locked !== 1'b0) begin
                errors++; $display("FAIL fail_flags_m%0d: fail=%b locked=%b expected 1 0", m, fail, locked);
            end
            checks++;
            if (lock_tap !== 4'd0 || tap_sel !== 4'd0) begin
                errors++; $display("FAIL fail_taps_m%0d: lock_tap=%0d tap_sel=%0d expected 0 0", m, lock_tap, tap_sel);
            end
            step(2);
        end
    endtask

    task automatic test_noise();
        int lat;
        mode = 3;
        run_sweep(lat);
        checks++;
        if (lat !== 201) begin errors++; $display("FAIL noise_latency: got %0d expected 201", lat); end
        checks++;
        if (lock_tap !== 4'd7 || locked !== 1'b1) begin
            errors++; $display("FAIL noise_lock: lock_tap=%0d locked=%b expected 7 1", lock_tap, locked);
        end
        step(2);
    endtask

    task automatic test_busy_ignore();
        int lat;
        mode  = 2;
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_set: got %b expected 1", busy); end
        lat = -1;
        for (int n = 1; n <= 1000; n++) begin
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            start = (n == 30);
            step(1);
        end
        start = 1'b0;
        checks++;
        if (lat !== 151 || lock_tap !== 4'd5) begin
            errors++; $display("FAIL start_while_busy: lat=%0d lock_tap=%0d expected 151 5", lat, lock_tap);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: busy=%b expected 0", busy); end
        step(2);
    endtask

    task automatic test_reset_mid();
        int done_seen;
        mode  = 2;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(40);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tap_sel, busy, done, locked, fail, lock_tap} !== 12'h000) begin
            errors++; $display("FAIL mid_reset_vals: got %h expected 000", {tap_sel, busy, done, locked, fail, lock_tap});
        end
        step(2);
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 200; n++) begin
            step(1);
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || busy !== 1'b0 || locked !== 1'b0) begin
            errors++; $display("FAIL mid_reset_abort: done_seen=%0d busy=%b locked=%b expected 0 0 0", done_seen, busy, locked);
        end
    endtask

`ifdef DLY_CAL_TRACK_EN
    task automatic test_track();
        int lat;
        int exp_tap;
        mode = 2;
        run_sweep(lat);
        mode = 0;
        checks++;
        if (lat !== 151 || lock_tap !== 4'd5) begin
            errors++; $display("FAIL track_lock: lat=%0d lock_tap=%0d expected 151 5", lat, lock_tap);
        end
        step(28);
        for (int k = 1; k <= 12; k++) begin
            exp_tap = (5 + k > 15) ? 15 : 5 + k;
            checks++;
            if (tap_sel !== 4'(exp_tap) || lock_tap !== 4'(exp_tap) || locked !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL track_step_%0d: tap_sel=%0d lock_tap=%0d locked=%b busy=%b expected %0d %0d 1 0",
                         k, tap_sel, lock_tap, locked, busy, exp_tap, exp_tap);
            end
            step(24);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_edge_lock();
        test_fail();
        test_noise();
        test_busy_ignore();
        test_reset_mid();
`ifdef DLY_CAL_TRACK_EN
        test_track();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
